aes_inv_cipher_iter: RTL and testbench
======================================

Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse-cipher core. It decrypts one 128-bit block using a single registered state and one inverse round per clock. It sits directly upstream of the decrypt output path and is the sequencer that feeds the inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) with state and the correct round key each cycle. The pre-expanded key schedule is supplied by the key-expansion block.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8).
Nr, 10, number of rounds (10/12/14; must match Nk).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to decrypt; sampled only in IDLE.
ciphertext  input  [0:127]  input block; sampled on the accepted-start edge only.
round_keys  input  [0:128*(Nr+1)-1]  expanded schedule. rk[i] = round_keys[128*i +: 128]; rk[0] is the cipher key's first round. Must be held stable while busy.
busy  output  1  high from the accepted-start edge until the final-round edge.
done  output  1  one-cycle pulse; plaintext is valid in this cycle.
plaintext  output  [0:127]  result register; holds its value until the next completion.

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE, state reg = 0, round counter = 0.
  - busy = 0, done = 0, plaintext = 0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE & start=1, at the edge:
  - state <= ciphertext ^ rk[Nr]
  - rnd <= Nr-1
  - busy <= 1
  - next state = ROUND
- ROUND, at each edge:
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[rnd]))
  - rnd <= rnd-1
  - if rnd==1, next state = FINAL
  - Exactly Nr-1 ROUND cycles, using rk[Nr-1] down to rk[1].
- FINAL, at the edge:
  - plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk[0], with no InvMixColumns.
  - done <= 1, busy <= 0.
  - next state = IDLE.
- done is registered and deasserts on the following edge unless another block completes.
- Latency: start sampled at edge E. done=1 and plaintext valid in the cycle after edge E+Nr (10/12/14 cycles for AES-128/192/256).
- Throughput: one block per Nr+1 cycles. A start asserted in the done cycle is accepted, since the FSM is already IDLE; plaintext then holds until the new completion.
- start while busy: ignored, no queuing; ciphertext changes while busy have no effect.
- Round counter: width $clog2(Nr+1); never wraps below 1 in ROUND.
- Reset mid-operation: immediate abort; all outputs return to reset values and no done pulse is issued.
- Byte order: bit 0 is the MSB of byte 0. State column c occupies bytes 4c..4c+3, per FIPS-197.
- All round logic is combinational between the state reg and its D input. No other pipeline registers.

Test Plan:
- AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f (schedule from the bench model), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse → done exactly 10 cycles after the start edge, plaintext 00112233445566778899aabbccddeeff, busy high 10 cycles.
- AES-256 (Nk=8, Nr=14, FIPS-197 C.3): key 000102…1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → done after 14 cycles, plaintext 00112233445566778899aabbccddeeff.
- start held high continuously with C.1 vectors → a done pulse every 11 cycles, each with the same plaintext; ciphertext toggled while busy has no effect on the result.
- Back-to-back: second start asserted exactly in the done cycle with ciphertext = the C.1 ciphertext re-encrypted under a different key → first plaintext holds until the second done, 10 cycles later, then updates to the correct value.
- Reset: rst_n pulsed low at cycle 5 of a block → busy, done and plaintext go to 0 asynchronously, no done pulse follows; a fresh start afterwards produces the correct C.1 result.
- Idle hold: no start for 50 cycles after completion → plaintext stable, done=0, busy=0.

Source files
------------

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock on a single state register.
// The round key for each cycle is selected from the pre-expanded schedule by a down-counter.
module aes_inv_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [0:127]          ciphertext,
   input  logic [0:128*(Nr+1)-1] round_keys,
   output logic                  busy,
   output logic                  done,
   output logic [0:127]          plaintext
);

   localparam int RW = $clog2(Nr + 1);

   if (Nr != Nk + 6) begin : g_param_check
      $error("aes_inv_cipher_iter: Nr must equal Nk+6");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } fsm_e;

   // All control state in one struct so checkers can bind to a single signal.
   typedef struct packed {
      fsm_e          fsm;
      logic [RW-1:0] rnd;
      logic          busy;
      logic          done;
   } ctrl_t;

   ctrl_t        ctrl_q, ctrl_d;
   logic [0:127] state_q, state_d;
   logic [0:127] pt_q, pt_d;
   logic [0:127] core;
   logic [0:127] rk [0:Nr];

   for (genvar i = 0; i <= Nr; i++) begin : g_rk
      assign rk[i] = round_keys[128*i +: 128];
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 via a short addition chain; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a6   = gf_mul(a3, a3);
      a12  = gf_mul(a6, a6);
      a15  = gf_mul(a12, a3);
      a30  = gf_mul(a15, a15);
      a60  = gf_mul(a30, a30);
      a120 = gf_mul(a60, a60);
      a240 = gf_mul(a120, a120);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] y;
      y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      end
      return o;
   endfunction

   function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c      +: 8];
         a1 = s[32*c + 8  +: 8];
         a2 = s[32*c + 16 +: 8];
         a3 = s[32*c + 24 +: 8];
         o[32*c      +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[32*c + 8  +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[32*c + 16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[32*c + 24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Shared by ROUND and FINAL; only the key and InvMixColumns differ.
   assign core = inv_sub_bytes(inv_shift_rows(state_q));

   always_comb begin
      ctrl_d      = ctrl_q;
      ctrl_d.done = 1'b0;
      state_d     = state_q;
      pt_d        = pt_q;
      case (ctrl_q.fsm)
         IDLE: begin
            if (start) begin
               state_d     = ciphertext ^ rk[Nr];
               ctrl_d.rnd  = RW'(Nr - 1);
               ctrl_d.busy = 1'b1;
               ctrl_d.fsm  = ROUND;
            end
         end
         ROUND: begin
            state_d    = inv_mix_columns(core ^ rk[ctrl_q.rnd]);
            ctrl_d.rnd = ctrl_q.rnd - 1'b1;
            if (ctrl_q.rnd == RW'(1)) ctrl_d.fsm = FINAL;
         end
         FINAL: begin
            pt_d        = core ^ rk[0];
            ctrl_d.done = 1'b1;
            ctrl_d.busy = 1'b0;
            ctrl_d.fsm  = IDLE;
         end
         default: begin
            ctrl_d.fsm = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= '{fsm: IDLE, rnd: '0, busy: 1'b0, done: 1'b0};
         state_q <= '0;
         pt_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         state_q <= state_d;
         pt_q    <= pt_d;
      end
   end

   assign busy      = ctrl_q.busy;
   assign done      = ctrl_q.done;
   assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128 and AES-256 instances checked against a
// forward-cipher reference model; expected plaintexts flow through a queue to a done monitor.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] REF_PT = 128'h00112233445566778899aabbccddeeff;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // stimulus and DUT wiring
   logic                  start_r;
   logic                  use256;
   logic [127:0]          ct_r;
   logic [0:128*11-1]     rk128_bus;
   logic [0:128*15-1]     rk256_bus;
   logic                  start128, start256;
   logic                  busy128, done128, busy256, done256;
   logic [127:0]          pt128, pt256;
   logic                  busy_s, done_s;
   logic [127:0]          pt_s;

   assign start128 = start_r & ~use256;
   assign start256 = start_r & use256;
   assign busy_s   = use256 ? busy256 : busy128;
   assign done_s   = use256 ? done256 : done128;
   assign pt_s     = use256 ? pt256   : pt128;

   aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start128),
      .ciphertext (ct_r),
      .round_keys (rk128_bus),
      .busy       (busy128),
      .done       (done128),
      .plaintext  (pt128)
   );

   aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start256),
      .ciphertext (ct_r),
      .round_keys (rk256_bus),
      .busy       (busy256),
      .done       (done256),
      .plaintext  (pt256)
   );

   // scoreboard
   logic [127:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1 && done_s === 1'b1) begin
         if (exp_q.size() == 0) check_eq("done_unexpected", 128'(done_s), 128'd0);
         else check_eq("plaintext", pt_s, exp_q.pop_front());
      end
   end

   // reference model: forward AES from FIPS-197 tables
   logic [7:0]   sbox [0:255];
   logic [127:0] rk_m [0:14];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
      logic [31:0] w [0:59];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp  = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subword(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r <= nr; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [127:0] v;
      v = pt ^ rk_m[0];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) t[4*c+k] = s[4*((c+k)%4)+k];
         for (int c = 0; c < 4; c++) begin
            if (r != nr) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
            end
         end
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
         v = v ^ rk_m[r];
      end
      return v;
   endfunction

   // driver tasks
   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bus();
      if (use256) for (int i = 0; i <= 14; i++) rk256_bus[128*i +: 128] = rk_m[i];
      else        for (int i = 0; i <= 10; i++) rk128_bus[128*i +: 128] = rk_m[i];
   endtask

   // Starts one block from IDLE and returns in its done cycle.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt, input string tag);
      int lat;
      int cyc;
      int busy_cnt;
      lat = use256 ? 14 : 10;
      start_r = 1'b1;
      ct_r    = ct;
      exp_q.push_back(exp_pt);
      tick();
      start_r  = 1'b0;
      cyc      = 0;
      busy_cnt = busy_s ? 1 : 0;
      while (done_s !== 1'b1 && cyc < 40) begin
         ct_r = rand128();
         tick();
         cyc++;
         if (busy_s === 1'b1) busy_cnt++;
      end
      check_eq({tag, "_latency"}, 128'(cyc), 128'(lat));
      check_eq({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(lat));
      check_eq({tag, "_done"}, 128'(done_s), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pt, ct2;
      logic [255:0] key;
      int cyc, n_done, last, bad, busy_seen, done_seen;

      rst_n = 1'b0; start_r = 1'b0; use256 = 1'b0; ct_r = '0;
      rk128_bus = '0; rk256_bus = '0;
      init_sbox();
      tick(); tick(); tick();
      check_eq("rst_busy128", 128'(busy128), 128'd0);
      check_eq("rst_done128", 128'(done128), 128'd0);
      check_eq("rst_pt128",   pt128, 128'd0);
      check_eq("rst_busy256", 128'(busy256), 128'd0);
      check_eq("rst_done256", 128'(done256), 128'd0);
      check_eq("rst_pt256",   pt256, 128'd0);
      rst_n = 1'b1;
      tick();

      // reference model against the known FIPS-197 vectors
      expand_key({C3_KEY}, 8, 14);
      check_eq("model_c3", encrypt(REF_PT, 14), C3_CT);
      expand_key({C1_KEY, 128'h0}, 4, 10);
      check_eq("model_c1", encrypt(REF_PT, 10), C1_CT);

      // AES-128 C.1
      use256 = 1'b0;
      load_bus();
      run_block(C1_CT, REF_PT, "c1");
      tick();
      check_eq("c1_done_pulse", 128'(done_s), 128'd0);

      // AES-256 C.3
      use256 = 1'b1;
      expand_key(C3_KEY, 8, 14);
      load_bus();
      run_block(C3_CT, REF_PT, "c3");
      tick();
      check_eq("c3_done_pulse", 128'(done_s), 128'd0);

      // random keys and blocks on both key sizes
      for (int n = 0; n < 10; n++) begin
         use256 = (n % 2) == 1;
         key    = {rand128(), rand128()};
         pt     = rand128();
         if (use256) expand_key(key, 8, 14);
         else        expand_key(key, 4, 10);
         ct2 = encrypt(pt, use256 ? 14 : 10);
         load_bus();
         run_block(ct2, pt, use256 ? "rand256" : "rand128");
         tick();
      end

      // start held high: one block every 11 cycles, ciphertext noise while busy
      use256 = 1'b0;
      expand_key({C1_KEY, 128'h0}, 4, 10);
      load_bus();
      for (int i = 0; i < 3; i++) exp_q.push_back(REF_PT);
      start_r = 1'b1;
      ct_r    = C1_CT;
      tick();
      ct_r = rand128();
      cyc = 0; n_done = 0; last = 0;
      while (n_done < 3 && cyc < 60) begin
         tick();
         cyc++;
         if (done_s === 1'b1) begin
            n_done++;
            if (n_done > 1) check_eq("held_interval", 128'(cyc - last), 128'd11);
            last = cyc;
            if (n_done == 3) start_r = 1'b0;
            else ct_r = C1_CT;
         end else begin
            ct_r = rand128();
         end
      end
      check_eq("held_count", 128'(n_done), 128'd3);
      tick();

      // back-to-back: second start in the done cycle under a different key
      run_block(C1_CT, REF_PT, "b2b_first");
      key = {rand128(), 128'h0};
      expand_key(key, 4, 10);
      ct2 = encrypt(C1_CT, 10);
      load_bus();
      start_r = 1'b1;
      ct_r    = ct2;
      exp_q.push_back(C1_CT);
      tick();
      start_r = 1'b0;
      cyc = 0; bad = 0;
      while (done_s !== 1'b1 && cyc < 40) begin
         if (pt_s !== REF_PT) bad++;
         ct_r = rand128();
         tick();
         cyc++;
      end
      check_eq("b2b_hold", 128'(bad), 128'd0);
      check_eq("b2b_latency", 128'(cyc), 128'd10);
      tick();

      // asynchronous reset in cycle 5 of a block
      expand_key({C1_KEY, 128'h0}, 4, 10);
      load_bus();
      start_r = 1'b1;
      ct_r    = C1_CT;
      tick();
      start_r = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #2;
      check_eq("abort_busy", 128'(busy128), 128'd0);
      check_eq("abort_done", 128'(done128), 128'd0);
      check_eq("abort_pt",   pt128, 128'd0);
      tick(); tick();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done_s === 1'b1) done_seen++;
      end
      check_eq("abort_no_done", 128'(done_seen), 128'd0);
      run_block(C1_CT, REF_PT, "post_reset");
      tick();

      // idle hold
      done_seen = 0; busy_seen = 0; bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done_s !== 1'b0) done_seen++;
         if (busy_s !== 1'b0) busy_seen++;
         if (pt_s !== REF_PT) bad++;
      end
      check_eq("idle_done", 128'(done_seen), 128'd0);
      check_eq("idle_busy", 128'(busy_seen), 128'd0);
      check_eq("idle_pt_stable", 128'(bad), 128'd0);
      check_eq("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
